// File: rtl/jt12_acc_seq_if.sv
// Configuration write bus for the accumulator slot sequencer.
// The master drives one channel-table write per clk_en edge.
interface jt12_acc_seq_if;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [2:0] cfg_alg;
    logic [1:0] cfg_rl;

    modport master (output cfg_we, cfg_ch, cfg_alg, cfg_rl);
    modport slave  (input  cfg_we, cfg_ch, cfg_alg, cfg_rl);
endinterface

// File: rtl/jt12_acc_seq.sv
// Accumulator slot sequencer: walks 24 slots per frame (4 operator groups x
// 6 channels) and presents registered per-slot decodes together with the
// channel configuration. Configuration is double-buffered: writes land in a
// pending table and are promoted to the active table only on the frame wrap,
// so a frame never sees a configuration change part way through.
//
// state     | meaning
// ST_FIRST  | first output frame after reset, sample_rdy suppressed
// ST_RUN    | steady state, sample_rdy pulses at output slot 1
module jt12_acc_seq (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    jt12_acc_seq_if.slave           cfg,
    input  logic [5:0]              ch_mask,
    input  logic                    pcm_en_in,
    output logic                    zero,
    output logic                    s1_enters,
    output logic                    s2_enters,
    output logic                    s3_enters,
    output logic                    s4_enters,
    output logic                    ch6op,
    output logic [2:0]              alg,
    output logic [1:0]              rl,
    output logic                    channel_en,
    output logic                    pcm_en,
    output logic [4:0]              slot,
    output logic                    sample_rdy
);

    typedef enum logic {ST_FIRST, ST_RUN} frame_state_t;

    frame_state_t state, state_nxt;

    logic [4:0] cnt;
    logic [1:0] cur_grp;
    logic [2:0] cur_ch;
    logic       wrap;

    logic [2:0] pend_alg [6];
    logic [1:0] pend_rl  [6];
    logic [5:0] pend_mask;
    logic       pend_pcm;

    logic [2:0] act_alg [6];
    logic [1:0] act_rl  [6];
    logic [5:0] act_mask;
    logic       act_pcm;

    assign wrap = (cnt == 5'd23);

    // Split cnt into group and channel; the channel offset is taken modulo 8
    // on the low three bits, which is exact because the result is always 0-5.
    always_comb begin
        cur_grp = 2'd0;
        cur_ch  = cnt[2:0];
        if (cnt < 5'd6) begin
            cur_grp = 2'd0;
            cur_ch  = cnt[2:0];
        end else if (cnt < 5'd12) begin
            cur_grp = 2'd1;
            cur_ch  = cnt[2:0] - 3'd6;
        end else if (cnt < 5'd18) begin
            cur_grp = 2'd2;
            cur_ch  = cnt[2:0] - 3'd4;
        end else begin
            cur_grp = 2'd3;
            cur_ch  = cnt[2:0] - 3'd2;
        end
    end

    // Slot counter and registered slot decodes (one clk_en behind cnt).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 5'd0;
            slot       <= 5'd0;
            zero       <= 1'b0;
            s1_enters  <= 1'b0;
            s2_enters  <= 1'b0;
            s3_enters  <= 1'b0;
            s4_enters  <= 1'b0;
            ch6op      <= 1'b0;
            alg        <= 3'd0;
            rl         <= 2'd0;
            channel_en <= 1'b0;
            pcm_en     <= 1'b0;
            sample_rdy <= 1'b0;
        end else if (clk_en) begin
            cnt        <= wrap ? 5'd0 : cnt + 5'd1;
            slot       <= cnt;
            zero       <= (cnt == 5'd0);
            s1_enters  <= (cur_grp == 2'd0);
            s3_enters  <= (cur_grp == 2'd1);
            s2_enters  <= (cur_grp == 2'd2);
            s4_enters  <= (cur_grp == 2'd3);
            ch6op      <= (cur_ch == 3'd5);
            alg        <= act_alg[cur_ch];
            rl         <= act_rl[cur_ch];
            channel_en <= ~act_mask[cur_ch];
            pcm_en     <= act_pcm;
            sample_rdy <= (cnt == 5'd1) && (state == ST_RUN);
        end
    end

    // Pending configuration: table writes plus per-edge mask/PCM sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                pend_alg[i] <= 3'd0;
                pend_rl[i]  <= 2'b11;
            end
            pend_mask <= 6'd0;
            pend_pcm  <= 1'b0;
        end else if (clk_en) begin
            if (cfg.cfg_we && (cfg.cfg_ch < 3'd6)) begin
                pend_alg[cfg.cfg_ch] <= cfg.cfg_alg;
                pend_rl[cfg.cfg_ch]  <= cfg.cfg_rl;
            end
            pend_mask <= ch_mask;
            pend_pcm  <= pcm_en_in;
        end
    end

    // Shadow copy at the frame wrap; reads pending as it was before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                act_alg[i] <= 3'd0;
                act_rl[i]  <= 2'b11;
            end
            act_mask <= 6'd0;
            act_pcm  <= 1'b0;
        end else if (clk_en && wrap) begin
            for (int i = 0; i < 6; i++) begin
                act_alg[i] <= pend_alg[i];
                act_rl[i]  <= pend_rl[i];
            end
            act_mask <= pend_mask;
            act_pcm  <= pend_pcm;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave the first frame once its last slot has been issued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FIRST: if (clk_en && wrap) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_FIRST;
        endcase
    end

endmodule
